// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY receive-path types: symbol constants, deskew FSM states, lane symbol payload.
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    COLLECT,
    LOCKED
  } deskew_state_t;

  typedef struct packed {
    logic       valid;
    logic       k;
    logic [7:0] data;
  } lane_sym_t;

  function automatic logic is_com(input lane_sym_t s);
    return s.valid & s.k & (s.data == COM_SYM);
  endfunction

endpackage

// File: rtl/lane_delay_line.sv
// One lane's symbol delay line: input register plus MAXSKEW shift stages, tap-selected output.
module lane_delay_line
  import pcie_phy_pkg::*;
#(
  parameter  int unsigned MAXSKEW = 4,
  localparam int unsigned DW      = $clog2(MAXSKEW + 1)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic          rx_k,
  input  logic [7:0]    rx_data,
  input  logic [DW-1:0] tap,
  output logic          aligned_valid,
  output logic          aligned_k,
  output logic [7:0]    aligned_data
);

  lane_sym_t [MAXSKEW:0] stage;
  lane_sym_t             head;
  lane_sym_t             sel;

  assign head = '{valid: rx_valid, k: rx_k, data: rx_data};

  // Stage 0 is the input register; stage j holds the symbol sampled j cycles earlier.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[MAXSKEW-1:0], head};
    end
  end

  always_comb begin
    sel = stage[0];
    for (int unsigned j = 1; j <= MAXSKEW; j++) begin
      if (tap == DW'(j)) sel = stage[j];
    end
  end

  assign aligned_valid = sel.valid;
  assign aligned_k     = sel.k;
  assign aligned_data  = sel.data;

endmodule

// File: rtl/rx_lane_deskew.sv
// Multi-lane RX deskew: measures COM arrival skew per lane and delays early lanes to align them.
module rx_lane_deskew
  import pcie_phy_pkg::*;
#(
  parameter  int unsigned LANESNUMBER = 16,
  parameter  int unsigned MAXSKEW     = 4,
  localparam int unsigned DW          = $clog2(MAXSKEW + 1)
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     deskew_en,
  input  logic [LANESNUMBER-1:0]   lane_mask,
  input  logic [8*LANESNUMBER-1:0] RxData,
  input  logic [LANESNUMBER-1:0]   RxDataK,
  input  logic [LANESNUMBER-1:0]   RxValid,
  output logic [8*LANESNUMBER-1:0] AlignedData,
  output logic [LANESNUMBER-1:0]   AlignedDataK,
  output logic [LANESNUMBER-1:0]   AlignedValid,
  output logic                     deskew_locked,
  output logic                     deskew_err,
  output logic [DW*LANESNUMBER-1:0] lane_delay
);

  localparam int unsigned CW = DW + 1;

  deskew_state_t state, state_nx;

  logic [LANESNUMBER-1:0]         seen, seen_nx;
  logic [LANESNUMBER-1:0]         com_in, com_out;
  logic [LANESNUMBER-1:0]         mask_q;
  logic [CW-1:0]                  cnt, cnt_nx;
  logic [LANESNUMBER-1:0][CW-1:0] arrival, arrival_nx;
  logic [LANESNUMBER-1:0][DW-1:0] delay_q, delay_nx, tap;
  logic                           locked_nx, err_nx, misalign;

  for (genvar i = 0; i < LANESNUMBER; i++) begin : g_lane
    assign com_in[i] = lane_mask[i] &
                       is_com(lane_sym_t'({RxValid[i], RxDataK[i], RxData[8*i +: 8]}));
    // Lanes outside the negotiated width bypass the measured delay.
    assign tap[i]    = lane_mask[i] ? delay_q[i] : '0;

    lane_delay_line #(.MAXSKEW(MAXSKEW)) u_delay (
      .CLK          (CLK),
      .reset        (reset),
      .rx_valid     (RxValid[i]),
      .rx_k         (RxDataK[i]),
      .rx_data      (RxData[8*i +: 8]),
      .tap          (tap[i]),
      .aligned_valid(AlignedValid[i]),
      .aligned_k    (AlignedDataK[i]),
      .aligned_data (AlignedData[8*i +: 8])
    );

    assign com_out[i] = lane_mask[i] &
                        is_com(lane_sym_t'({AlignedValid[i], AlignedDataK[i], AlignedData[8*i +: 8]}));
  end

  // A COM on some active lane while another valid active lane shows something else.
  assign misalign   = (|com_out) & (|(AlignedValid & lane_mask & ~com_out));
  assign lane_delay = delay_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      seen          <= '0;
      cnt           <= '0;
      arrival       <= '0;
      delay_q       <= '0;
      deskew_locked <= 1'b0;
      deskew_err    <= 1'b0;
      mask_q        <= '0;
    end else begin
      state         <= state_nx;
      seen          <= seen_nx;
      cnt           <= cnt_nx;
      arrival       <= arrival_nx;
      delay_q       <= delay_nx;
      deskew_locked <= locked_nx;
      deskew_err    <= err_nx;
      mask_q        <= lane_mask;
    end
  end

  always_comb begin
    state_nx   = state;
    seen_nx    = seen;
    cnt_nx     = cnt;
    arrival_nx = arrival;
    delay_nx   = delay_q;
    locked_nx  = deskew_locked;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        delay_nx  = '0;
        locked_nx = 1'b0;
        if (deskew_en) state_nx = WAIT_FIRST;
      end

      WAIT_FIRST: begin
        delay_nx  = '0;
        locked_nx = 1'b0;
        if (|com_in) begin
          seen_nx    = com_in;
          arrival_nx = '0;
          cnt_nx     = CW'(1);
          if (com_in == lane_mask) begin
            locked_nx = 1'b1;
            state_nx  = LOCKED;
          end else begin
            state_nx  = COLLECT;
          end
        end
      end

      COLLECT: begin
        for (int i = 0; i < LANESNUMBER; i++) begin
          if (com_in[i] && !seen[i]) begin
            arrival_nx[i] = cnt;
            seen_nx[i]    = 1'b1;
          end
        end
        cnt_nx = cnt + CW'(1);
        // A final arrival on the last legal count wins over the overflow.
        if ((seen_nx & lane_mask) == lane_mask) begin
          for (int i = 0; i < LANESNUMBER; i++) begin
            delay_nx[i] = lane_mask[i] ? DW'(cnt - arrival_nx[i]) : '0;
          end
          locked_nx = 1'b1;
          state_nx  = LOCKED;
        end else if (cnt >= CW'(MAXSKEW)) begin
          err_nx   = 1'b1;
          seen_nx  = '0;
          state_nx = WAIT_FIRST;
        end
      end

      LOCKED: begin
        if (lane_mask != mask_q) begin
          delay_nx  = '0;
          locked_nx = 1'b0;
          seen_nx   = '0;
          state_nx  = WAIT_FIRST;
        end else if (misalign) begin
          err_nx    = 1'b1;
          delay_nx  = '0;
          locked_nx = 1'b0;
          seen_nx   = '0;
          state_nx  = WAIT_FIRST;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (!deskew_en) begin
      state_nx  = IDLE;
      delay_nx  = '0;
      locked_nx = 1'b0;
      err_nx    = 1'b0;
      seen_nx   = '0;
    end
  end

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Self-checking bench for rx_lane_deskew: skew vector table plus hand-written corner sequences.
module tb_rx_lane_deskew;

  localparam int N  = 16;
  localparam int DW = 3;
  localparam logic [9:0] COM10 = {1'b1, 1'b1, 8'hBC};

  logic            CLK = 1'b0;
  logic            reset;
  logic            deskew_en;
  logic [N-1:0]    lane_mask;
  logic [8*N-1:0]  RxData;
  logic [N-1:0]    RxDataK;
  logic [N-1:0]    RxValid;
  logic [8*N-1:0]  AlignedData;
  logic [N-1:0]    AlignedDataK;
  logic [N-1:0]    AlignedValid;
  logic            deskew_locked;
  logic            deskew_err;
  logic [DW*N-1:0] lane_delay;

  rx_lane_deskew #(.LANESNUMBER(N), .MAXSKEW(4)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .deskew_en    (deskew_en),
    .lane_mask    (lane_mask),
    .RxData       (RxData),
    .RxDataK      (RxDataK),
    .RxValid      (RxValid),
    .AlignedData  (AlignedData),
    .AlignedDataK (AlignedDataK),
    .AlignedValid (AlignedValid),
    .deskew_locked(deskew_locked),
    .deskew_err   (deskew_err),
    .lane_delay   (lane_delay)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0]         mask;
    logic [N-1:0][3:0]    skew;       // edge of the COM per lane, 4'hF = none
    logic                 exp_lock;
    logic [3:0]           exp_lock_edge;
    logic [N-1:0][DW-1:0] exp_delay;
    logic [3:0]           exp_err;
  } vec_t;

  typedef struct {
    int         due;
    int         lane;
    logic [9:0] sym;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[6];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [9:0] s);
    RxValid[i]       = s[9];
    RxDataK[i]       = s[8];
    RxData[8*i +: 8] = s[7:0];
  endtask

  task automatic fill_all(input int t);
    for (int i = 0; i < N; i++) set_lane(i, {1'b1, 1'b0, 8'(i * 7 + t)});
  endtask

  // Advance one edge, sample 1 time unit later, retire due scoreboard entries.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    for (int j = int'(sbq.size()) - 1; j >= 0; j--) begin
      if (sbq[j].due <= cyc) begin
        chk($sformatf("sb_lane%0d_cyc%0d", sbq[j].lane, sbq[j].due),
            {54'd0, AlignedValid[sbq[j].lane], AlignedDataK[sbq[j].lane],
             AlignedData[8*sbq[j].lane +: 8]},
            {54'd0, sbq[j].sym});
        sbq.delete(j);
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    deskew_en = 1'b0;
    lane_mask = '0;
    RxData    = '0;
    RxDataK   = '0;
    RxValid   = '0;
    sbq.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic lock_start(input logic [N-1:0] mask);
    do_reset();
    deskew_en = 1'b1;
    lane_mask = mask;
    fill_all(0);
    step();
  endtask

  // Post-lock traffic with one skewed COM burst; every symbol is expected after 1+delay cycles.
  task automatic run_traffic(input string tag, input logic [N-1:0][DW-1:0] dly,
                             input logic [N-1:0][3:0] skew, input logic [N-1:0] mask);
    int errs = 0;
    int unl  = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [9:0] s;
        if (mask[i] && skew[i] != 4'hF && c == 4 + int'(skew[i])) s = COM10;
        else s = {($urandom_range(0, 3) != 0), 1'b0, 8'($urandom)};
        set_lane(i, s);
        sbq.push_back('{due: cyc + 1 + int'(mask[i] ? dly[i] : 3'd0), lane: i, sym: s});
      end
      step();
      errs += int'(deskew_err);
      unl  += int'(!deskew_locked);
    end
    fill_all(3);
    for (int c = 0; c < 6; c++) begin
      step();
      errs += int'(deskew_err);
    end
    chk({tag, "_sb_drained"}, 64'(sbq.size()), 64'd0);
    chk({tag, "_traffic_err"}, 64'(errs), 64'd0);
    chk({tag, "_traffic_unlock"}, 64'(unl), 64'd0);
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    int   errs      = 0;
    logic [3:0] lock_edge = 4'hF;
    lock_start(v.mask);
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) begin
        if (v.skew[i] == 4'(t)) set_lane(i, COM10);
        else set_lane(i, {1'b1, 1'b0, 8'(i * 7 + t)});
      end
      step();
      errs += int'(deskew_err);
      if (deskew_locked && lock_edge == 4'hF) lock_edge = 4'(t);
    end
    chk($sformatf("v%0d_locked", n), 64'(deskew_locked), 64'(v.exp_lock));
    chk($sformatf("v%0d_lock_edge", n), 64'(lock_edge), 64'(v.exp_lock_edge));
    chk($sformatf("v%0d_lane_delay", n), 64'(lane_delay), 64'(v.exp_delay));
    chk($sformatf("v%0d_err_pulses", n), 64'(errs), 64'(v.exp_err));
    if (v.exp_lock) run_traffic($sformatf("v%0d", n), v.exp_delay, v.skew, v.mask);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [N-1:0][DW-1:0] e;
    logic [N-1:0][3:0]    sk;
    int                   errs;

    // Vector table: zero skew, split skew, overflow, partial mask, max skew, sparse mask.
    v = '0; v.mask = 16'hFFFF; v.exp_lock = 1'b1; v.exp_lock_edge = 4'd0;
    vecs[0] = v;
    v = '0; v.mask = 16'hFFFF; v.skew = {{8{4'd2}}, {8{4'd0}}};
    v.exp_lock = 1'b1; v.exp_lock_edge = 4'd2; v.exp_delay = {{8{3'd0}}, {8{3'd2}}};
    vecs[1] = v;
    v = '0; v.mask = 16'hFFFF; v.skew[5] = 4'd5;
    v.exp_lock = 1'b0; v.exp_lock_edge = 4'hF; v.exp_err = 4'd2;
    vecs[2] = v;
    v = '0; v.mask = 16'h000F; v.skew = {16{4'hF}};
    v.skew[0] = 4'd0; v.skew[1] = 4'd1; v.skew[2] = 4'd2; v.skew[3] = 4'd3;
    v.exp_lock = 1'b1; v.exp_lock_edge = 4'd3;
    v.exp_delay[0] = 3'd3; v.exp_delay[1] = 3'd2; v.exp_delay[2] = 3'd1; v.exp_delay[3] = 3'd0;
    vecs[3] = v;
    v = '0; v.mask = 16'hFFFF; v.skew = {16{4'd4}}; v.skew[0] = 4'd0;
    v.exp_lock = 1'b1; v.exp_lock_edge = 4'd4; v.exp_delay[0] = 3'd4;
    vecs[4] = v;
    v = '0; v.mask = 16'h00F0; v.skew = {16{4'hF}};
    v.skew[0] = 4'd0; v.skew[4] = 4'd1; v.skew[5] = 4'd3; v.skew[6] = 4'd0; v.skew[7] = 4'd2;
    v.exp_lock = 1'b1; v.exp_lock_edge = 4'd3;
    v.exp_delay[4] = 3'd2; v.exp_delay[5] = 3'd0; v.exp_delay[6] = 3'd3; v.exp_delay[7] = 3'd1;
    vecs[5] = v;

    do_reset();
    chk("rst_aligned_valid", 64'(AlignedValid), 64'd0);
    chk("rst_locked", 64'(deskew_locked), 64'd0);
    chk("rst_err", 64'(deskew_err), 64'd0);
    chk("rst_lane_delay", 64'(lane_delay), 64'd0);

    for (int n = 0; n < 6; n++) apply_vec(n, vecs[n]);

    // Lock at zero skew, then lane 3 slips one symbol: error, unlock, relock.
    lock_start(16'hFFFF);
    for (int i = 0; i < N; i++) set_lane(i, COM10);
    step();
    chk("h1_locked", 64'(deskew_locked), 64'd1);
    chk("h1_delay0", 64'(lane_delay), 64'd0);
    for (int t = 0; t < 3; t++) begin fill_all(t); step(); end
    fill_all(5);
    for (int i = 0; i < N; i++) if (i != 3) set_lane(i, COM10);
    step();
    chk("h1_err_before", 64'(deskew_err), 64'd0);
    fill_all(6);
    set_lane(3, COM10);
    step();
    chk("h1_err_pulse", 64'(deskew_err), 64'd1);
    chk("h1_unlocked", 64'(deskew_locked), 64'd0);
    fill_all(7);
    step();
    chk("h1_err_one_cycle", 64'(deskew_err), 64'd0);
    step();
    for (int i = 0; i < N; i++) if (i != 3) set_lane(i, COM10);
    step();
    fill_all(8);
    set_lane(3, COM10);
    step();
    e = {16{3'd1}}; e[3] = 3'd0;
    sk = '0; sk[3] = 4'd1;
    chk("h1_relocked", 64'(deskew_locked), 64'd1);
    chk("h1_relock_delay", 64'(lane_delay), 64'(e));
    fill_all(9);
    run_traffic("h1", e, sk, 16'hFFFF);

    // Asynchronous reset while collecting arrivals.
    lock_start(16'hFFFF);
    for (int i = 0; i < 8; i++) set_lane(i, COM10);
    step();
    chk("h2_pre_valid", 64'(AlignedValid), 64'hFFFF);
    #2 reset = 1'b1;
    #1;
    chk("h2_rst_data", 64'(AlignedData[63:0]) | 64'(AlignedData[127:64]), 64'd0);
    chk("h2_rst_valid", 64'(AlignedValid | AlignedDataK), 64'd0);
    chk("h2_rst_locked", 64'(deskew_locked | deskew_err), 64'd0);
    chk("h2_rst_delay", 64'(lane_delay), 64'd0);
    fill_all(1);
    step();
    reset = 1'b0;
    for (int i = 8; i < N; i++) set_lane(i, COM10);
    step();
    errs = 0;
    fill_all(2);
    for (int t = 0; t < 6; t++) begin
      step();
      errs += int'(deskew_err) + int'(deskew_locked);
    end
    chk("h2_no_stale_collect", 64'(errs), 64'd0);

    // Mask change while locked, then relock on a narrower link and drop deskew_en.
    lock_start(16'hFFFF);
    for (int i = 0; i < N; i++) set_lane(i, COM10);
    step();
    fill_all(1);
    step();
    chk("h3_locked", 64'(deskew_locked), 64'd1);
    lane_mask = 16'h00FF;
    step();
    chk("h3_mask_unlock", 64'(deskew_locked), 64'd0);
    chk("h3_mask_no_err", 64'(deskew_err), 64'd0);
    for (int i = 0; i < 4; i++) set_lane(i, COM10);
    step();
    fill_all(2);
    for (int i = 4; i < 8; i++) set_lane(i, COM10);
    step();
    e = '0; e[0] = 3'd1; e[1] = 3'd1; e[2] = 3'd1; e[3] = 3'd1;
    chk("h3_relocked", 64'(deskew_locked), 64'd1);
    chk("h3_relock_delay", 64'(lane_delay), 64'(e));
    fill_all(3);
    step();
    deskew_en = 1'b0;
    step();
    chk("h3_en_off_locked", 64'(deskew_locked), 64'd0);
    chk("h3_en_off_delay", 64'(lane_delay), 64'd0);
    chk("h3_en_off_err", 64'(deskew_err), 64'd0);
    step();
    chk("h3_idle_locked", 64'(deskew_locked), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
